// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM states, parity encodings and default bit timing
package uart_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD = 2;
   localparam int DEF_CLKS_PER_BIT = 868;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal count
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);
   localparam int W = $clog2(CLKS_PER_BIT);
   logic [W-1:0] cnt;
   assign tick = cnt == W'(CLKS_PER_BIT - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a show-ahead FIFO and sends them as back-to-back UART frames
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int DWIDTH = 8,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int PARITY = PAR_NONE,
   parameter int STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              fifo_empty,
   input  logic [DWIDTH-1:0] fifo_rdata,
   output logic              fifo_rd,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);
   localparam int BW = $clog2(DWIDTH);
   state_t state;
   logic [DWIDTH-1:0] shreg;
   logic [BW-1:0] idx;
   logic par_bit, tick, pop, last;
   assign last = state == ST_STOP && tick && idx == BW'(STOP_BITS - 1);
   assign pop = en && !fifo_empty && (state == ST_IDLE || last);
   assign fifo_rd = pop && rst_n;
   assign tx_done = last;
   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk(clk),
      .rst_n(rst_n),
      .clr(pop || state == ST_IDLE),
      .tick(tick)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= ST_IDLE;
         shreg <= '0;
         idx <= '0;
         par_bit <= 1'b0;
         tx <= 1'b1;
         busy <= 1'b0;
      end else if (pop) begin
         state <= ST_START;
         shreg <= fifo_rdata;
         par_bit <= (PARITY == PAR_ODD) ^ (^fifo_rdata);
         idx <= '0;
         tx <= 1'b0;
         busy <= 1'b1;
      end else if (tick) begin
         case (state)
            ST_START: begin
               state <= ST_DATA;
               tx <= shreg[0];
            end
            ST_DATA: begin
               shreg <= shreg >> 1;
               if (idx == BW'(DWIDTH - 1)) begin
                  idx <= '0;
                  state <= PARITY == PAR_NONE ? ST_STOP : ST_PARITY;
                  tx <= PARITY == PAR_NONE ? 1'b1 : par_bit;
               end else begin
                  idx <= idx + 1'b1;
                  tx <= shreg[1];
               end
            end
            ST_PARITY: begin
               state <= ST_STOP;
               tx <= 1'b1;
            end
            ST_STOP:
               if (last) begin
                  state <= ST_IDLE;
                  busy <= 1'b0;
                  idx <= '0;
               end else idx <= idx + 1'b1;
            default: state <= ST_IDLE;
         endcase
      end
endmodule
